wb_write_port: RTL

Writeback-side driver for the CPU's 32x32 register file write port. It accepts register results from two producers, the ALU and the load/store unit, through valid/ready handshakes. Results are buffered in a small in-order queue, and at most one write per cycle is presented on the register file's write number, data and enable inputs. The register file commits on the falling clock edge, and this block changes its outputs only on the rising edge, so write inputs are stable at every commit. An optional bypass lookup reports pending, not-yet-committed writes for the two read ports.

---
 rtl/wb_write_port.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_write_port.sv
// Writeback driver for the register file write port: merges ALU and LSU results into an
// in-order queue and presents one write per cycle. Optional bypass lookup under `WB_BYPASS_EN`.
module wb_write_port #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    output logic          alu_ready,
    input  logic          lsu_valid,
    input  logic [4:0]    lsu_rd,
    input  logic [31:0]   lsu_data,
    output logic          lsu_ready,
    output logic          wr_en,
    output logic [4:0]    wr_no,
    output logic [31:0]   wr_data,
    output logic [CW-1:0] count,
    input  logic [4:0]    q1_no,
    input  logic [4:0]    q2_no,
    output logic          q1_hit,
    output logic          q2_hit,
    output logic [31:0]   q1_data,
    output logic [31:0]   q2_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [4:0]       rd_r   [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;

    logic [CW-1:0]    free_s;
    logic [CW-1:0]    cnt_next_s;
    logic [PW-1:0]    alu_idx_s;
    logic             lsu_push_s;
    logic             alu_push_s;
    logic             pop_s;

    // Handshake readiness from registered occupancy; LSU is served before the ALU.
    always_comb begin
        free_s    = DEPTH_C - count_r;
        lsu_ready = 1'b0;
        alu_ready = 1'b0;
        if (rst) begin
            lsu_ready = 1'b0;
            alu_ready = 1'b0;
        end else begin
            lsu_ready = (free_s >= CNT_ONE);
            alu_ready = (free_s >= CNT_TWO) || ((free_s == CNT_ONE) && !lsu_valid);
        end
    end

    // Transfers to x0 are acknowledged but never occupy a slot.
    always_comb begin
        lsu_push_s = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
        alu_push_s = alu_valid && alu_ready && (alu_rd != 5'd0);
        pop_s      = (count_r != CNT_ZERO);
        alu_idx_s  = tail_r;
        if (lsu_push_s) begin
            alu_idx_s = tail_r + PTR_ONE;
        end else begin
            alu_idx_s = tail_r;
        end
        cnt_next_s = count_r - CW'(pop_s) + CW'(lsu_push_s) + CW'(alu_push_s);
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= CNT_ZERO;
            vld_r   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i]   <= 5'd0;
                data_r[i] <= 32'd0;
            end
        end else begin
            if (pop_s) begin
                vld_r[head_r] <= 1'b0;
                head_r        <= head_r + PTR_ONE;
            end
            if (lsu_push_s) begin
                rd_r[tail_r]   <= lsu_rd;
                data_r[tail_r] <= lsu_data;
                vld_r[tail_r]  <= 1'b1;
            end
            if (alu_push_s) begin
                rd_r[alu_idx_s]   <= alu_rd;
                data_r[alu_idx_s] <= alu_data;
                vld_r[alu_idx_s]  <= 1'b1;
            end
            tail_r  <= tail_r + PW'(lsu_push_s) + PW'(alu_push_s);
            count_r <= cnt_next_s;
        end
    end

    // Head entry drives the write port; outputs are zero while the queue is empty.
    always_comb begin
        count   = count_r;
        wr_en   = (count_r != CNT_ZERO);
        wr_no   = 5'd0;
        wr_data = 32'd0;
        if (wr_en) begin
            wr_no   = rd_r[head_r];
            wr_data = data_r[head_r];
        end else begin
            wr_no   = 5'd0;
            wr_data = 32'd0;
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] idx_v;

    // Scan oldest to youngest so the last match seen is the youngest pending write.
    always_comb begin
        q1_hit  = 1'b0;
        q1_data = 32'd0;
        q2_hit  = 1'b0;
        q2_data = 32'd0;
        idx_v   = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            idx_v = head_r + PW'(i);
            if (vld_r[idx_v] && (q1_no != 5'd0) && (rd_r[idx_v] == q1_no)) begin
                q1_hit  = 1'b1;
                q1_data = data_r[idx_v];
            end else begin
                q1_hit  = q1_hit;
            end
            if (vld_r[idx_v] && (q2_no != 5'd0) && (rd_r[idx_v] == q2_no)) begin
                q2_hit  = 1'b1;
                q2_data = data_r[idx_v];
            end else begin
                q2_hit  = q2_hit;
            end
        end
    end
`else
    logic unused_s;

    // Lookup disabled: outputs tied low, query inputs and valid bits intentionally unused.
    always_comb begin
        q1_hit   = 1'b0;
        q1_data  = 32'd0;
        q2_hit   = 1'b0;
        q2_data  = 32'd0;
        unused_s = ^{q1_no, q2_no, vld_r};
    end
`endif

endmodule
